// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver oversampled on core_clk, feeding a show-ahead FIFO
// drained by a valid/ready handshake; framing errors and overflows pulse.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 40,
    parameter int FIFO_DEPTH   = 8,
    parameter int ADDR_W       = 3
) (
    input  logic              core_clk,
    input  logic              rst,
    input  logic              rxd,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [ADDR_W:0]   fifo_count,
    output logic              frame_err,
    output logic              overflow
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]  FULL_CNT  = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic             sync1;
    logic             rxs;
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_n;
    logic [7:0]       shreg;
    logic [7:0]       shreg_n;
    logic             push;
    logic             frame_err_n;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_n;
    logic              full;
    logic              pop;
    logic              push_ok;
    logic              overflow_n;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        push        = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            WAIT_IDLE: begin
                if (rxs) state_n = IDLE;
            end
            IDLE: begin
                if (!rxs) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    if (!rxs) begin
                        state_n   = DATA;
                        cnt_n     = '0;
                        bit_idx_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    shreg_n   = {rxs, shreg[7:1]};
                    cnt_n     = '0;
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_n = STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    // Leave mid stop bit so a back-to-back start edge is not missed
                    if (rxs) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = WAIT_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = WAIT_IDLE;
        endcase
    end

    assign rx_valid = (fifo_count != '0);
    assign rx_data  = mem[rd_ptr];
    assign full     = (fifo_count == FULL_CNT);
    assign pop      = rx_valid && rx_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign push_ok    = push && (!full || pop);
    assign overflow_n = push && !push_ok;

    always_comb begin
        count_n = fifo_count;
        case ({push_ok, pop})
            2'b10:   count_n = fifo_count + 1'b1;
            2'b01:   count_n = fifo_count - 1'b1;
            default: count_n = fifo_count;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (rst) begin
            sync1      <= 1'b1;
            rxs        <= 1'b1;
            state      <= WAIT_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            sync1      <= rxd;
            rxs        <= sync1;
            state      <= state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            fifo_count <= count_n;
            frame_err  <= frame_err_n;
            overflow   <= overflow_n;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge core_clk) begin
        if (push_ok) mem[wr_ptr] <= shreg;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table-driven frame vectors plus
// hand-written sequences for latency, overflow, same-cycle push/pop and reset.
module tb_uart_rx_fifo;

    localparam int CPB   = 40;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          core_clk = 1'b0;
    logic          rst      = 1'b1;
    logic          rxd      = 1'b1;
    logic          rx_ready = 1'b0;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [AW:0]   fifo_count;
    logic          frame_err;
    logic          overflow;

    uart_rx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .ADDR_W      (AW)
    ) dut (
        .core_clk  (core_clk),
        .rst       (rst),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .fifo_count(fifo_count),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 core_clk = ~core_clk;

    int checks = 0;
    int errors = 0;
    int ferr_cycles = 0;
    int ovf_cycles  = 0;
    int both_cycles = 0;
    logic [7:0] got[$];

    always @(negedge core_clk) begin
        if (frame_err === 1'b1) ferr_cycles++;
        if (overflow === 1'b1) ovf_cycles++;
        if (frame_err === 1'b1 && overflow === 1'b1) both_cycles++;
        if (rx_valid === 1'b1 && rx_ready === 1'b1) got.push_back(rx_data);
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       hold_low;
        int         exp_count;
        logic [7:0] exp_head;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge core_clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        send_bit(stop);
    endtask

    task automatic drain(input int cycles);
        rx_ready = 1'b1;
        tick(cycles);
        rx_ready = 1'b0;
    endtask

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int fbase;
        int obase;

        vecs[0] = '{8'h0D, 1'b1, 1'b0, 1, 8'h0D, 0};
        vecs[1] = '{8'h55, 1'b0, 1'b1, 1, 8'h0D, 1};
        vecs[2] = '{8'hA5, 1'b1, 1'b0, 2, 8'h0D, 1};
        vecs[3] = '{8'hFF, 1'b1, 1'b0, 3, 8'h0D, 1};
        vecs[4] = '{8'h80, 1'b1, 1'b0, 4, 8'h0D, 1};

        // Reset state
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        check("reset rx_valid", rx_valid, 0);
        check("reset fifo_count", fifo_count, 0);
        check("reset frame_err", frame_err, 0);
        check("reset overflow", overflow, 0);
        tick(CPB);

        // Single frame 0x0D: push lands 2 sync + 1 idle + 20 start cycles into the stop bit
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(((8'h0D >> i) & 8'h01) != 0);
        rxd = 1'b1;
        n = 0;
        while (rx_valid !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        check("stop-to-valid latency", n, 23);
        tick(2 * CPB);
        check("single rx_data", rx_data, 8'h0D);
        check("single fifo_count", fifo_count, 1);
        drain(4);
        check("single drained count", fifo_count, 0);

        // Table-driven frames with rx_ready low, including a framing error
        fbase = ferr_cycles;
        for (int v = 0; v < 5; v++) begin
            send_frame(vecs[v].data, vecs[v].stop);
            if (vecs[v].hold_low) send_bit(1'b0);
            send_bit(1'b1);
            check($sformatf("vec%0d fifo_count", v), fifo_count, vecs[v].exp_count);
            check($sformatf("vec%0d rx_valid", v), rx_valid, 1);
            check($sformatf("vec%0d rx_data", v), rx_data, vecs[v].exp_head);
            check($sformatf("vec%0d frame_err cycles", v), ferr_cycles - fbase, vecs[v].exp_ferr);
        end
        got.delete();
        drain(10);
        check("table drain size", got.size(), 4);
        check("table drain 0", got[0], 8'h0D);
        check("table drain 1", got[1], 8'hA5);
        check("table drain 2", got[2], 8'hFF);
        check("table drain 3", got[3], 8'h80);
        check("table drained count", fifo_count, 0);

        // Back-to-back frames with rx_ready held high
        got.delete();
        fbase = ferr_cycles;
        obase = ovf_cycles;
        rx_ready = 1'b1;
        send_frame(8'h0D, 1'b1);
        send_frame(8'h19, 1'b1);
        send_frame(8'h31, 1'b1);
        send_frame(8'h61, 1'b1);
        send_frame(8'h02, 1'b1);
        send_bit(1'b1);
        rx_ready = 1'b0;
        check("b2b count", got.size(), 5);
        check("b2b byte 0", got[0], 8'h0D);
        check("b2b byte 1", got[1], 8'h19);
        check("b2b byte 2", got[2], 8'h31);
        check("b2b byte 3", got[3], 8'h61);
        check("b2b byte 4", got[4], 8'h02);
        check("b2b frame_err", ferr_cycles - fbase, 0);
        check("b2b overflow", ovf_cycles - obase, 0);
        check("b2b fifo_count", fifo_count, 0);

        // 10-cycle low glitch while idle, then a normal frame
        fbase = ferr_cycles;
        rxd = 1'b0;
        tick(10);
        rxd = 1'b1;
        tick(2 * CPB);
        check("glitch fifo_count", fifo_count, 0);
        check("glitch frame_err", ferr_cycles - fbase, 0);
        send_frame(8'hC3, 1'b1);
        send_bit(1'b1);
        check("post-glitch count", fifo_count, 1);
        check("post-glitch data", rx_data, 8'hC3);
        drain(4);

        // Overflow: nine frames into an eight-entry FIFO
        obase = ovf_cycles;
        for (int i = 0; i < 9; i++) begin
            send_frame(i[7:0], 1'b1);
            send_bit(1'b1);
            if (i == 7) check("fill overflow before 9th", ovf_cycles - obase, 0);
        end
        check("full fifo_count", fifo_count, 8);
        check("overflow pulses", ovf_cycles - obase, 1);
        check("full head", rx_data, 8'h00);

        // Full FIFO: push and pop in the stop-sample cycle are both accepted
        got.delete();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(((8'h77 >> i) & 8'h01) != 0);
        rxd = 1'b1;
        tick(22);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(CPB - 23);
        send_bit(1'b1);
        check("full push+pop count", fifo_count, 8);
        check("full push+pop overflow", ovf_cycles - obase, 1);
        check("full push+pop popped", got.size(), 1);
        check("full push+pop popped byte", got[0], 8'h00);
        got.delete();
        drain(12);
        check("overflow drain size", got.size(), 8);
        for (int i = 0; i < 7; i++) check($sformatf("overflow drain %0d", i), got[i], i + 1);
        check("overflow drain last", got[7], 8'h77);
        check("overflow drained count", fifo_count, 0);

        // Reset in the middle of bit 3 discards FIFO contents and the partial frame
        send_frame(8'h11, 1'b1);
        send_bit(1'b1);
        check("pre-reset count", fifo_count, 1);
        fbase = ferr_cycles;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        rxd = 1'b0;
        tick(19);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid-frame reset count", fifo_count, 0);
        tick(CPB - 20);
        rxd = 1'b1;
        tick(2 * CPB);
        check("broken frame no byte", fifo_count, 0);
        send_frame(8'h3C, 1'b1);
        send_bit(1'b1);
        check("post-reset count", fifo_count, 1);
        check("post-reset data", rx_data, 8'h3C);
        check("post-reset frame_err", ferr_cycles - fbase, 0);
        drain(4);

        check("frame_err and overflow together", both_cycles, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
